mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
Pipeline MEMORY stage of the MIPS core. It sits directly downstream of EXECUTE and consumes the ex_mem_* pipeline registers (ALU result, store operand, control bits). It performs loads and stores over a req/ready handshake to the RAM, stalls the pipeline while an access is outstanding, and registers the write-back result into the mem_wb_* outputs for WRITEBACK.

Parameters:
MAX_WAIT, 255, maximum WAIT cycles without mem_ready before the access is aborted as a bus fault (1..255).

Ports:
clock  in  1  core clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-low reset.
ex_mem_aluout  in  32  ALU result; this is the byte address for loads/stores.
ex_mem_regb  in  32  store data, right-aligned.
ex_mem_readmem  in  1  load.
ex_mem_writemem  in  1  store. Never high together with ex_mem_readmem.
ex_mem_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
ex_mem_unsigned  in  1  zero-extend loads (1) or sign-extend (0).
ex_mem_regdest  in  5  destination register.
ex_mem_writereg  in  1  instruction writes the register file.
mem_stall  out  1  hold EXECUTE and upstream; ex_mem_* must stay stable while high.
mem_wb_result  out  32  load data or passed-through aluout.
mem_wb_regdest  out  5  registered ex_mem_regdest.
mem_wb_writereg  out  1  write-back enable.
mem_fault  out  1  one-cycle pulse on a misaligned access or a timeout.
mem_req  out  1  memory request, registered.
mem_we  out  1  1 = write.
mem_addr  out  32  word-aligned address ({aluout[31:2],2'b00}).
mem_be  out  4  byte enables.
mem_wdata  out  32  store data replicated into its lanes.
mem_ready  in  1  memory accepted the write or has read data valid this cycle.
mem_rdata  in  32  read word.

Behaviour:
- Reset (reset=0, async): state IDLE, wait counter 0, all outputs 0. A reset mid-access drops mem_req immediately; no write-back and no fault result from the aborted access.
- Byte lanes are little-endian: byte address offset k maps to lane k (bits 8k+7:8k).
  - Byte: be = 1<<k; wdata = regb[7:0] in all four lanes.
  - Half: be = 0011 or 1100; wdata = {regb[15:0],regb[15:0]}.
  - Word: be = 1111.
- Misaligned access: half with addr[0]=1, or word with addr[1:0]!=0. No request is issued and there is no stall. Next cycle: mem_fault=1, mem_wb_writereg=0.
- FSM states IDLE, WAIT.
  - IDLE, non-memory op: mem_stall=0. Next edge: mem_wb_result=aluout, regdest and writereg copied (1-cycle latency).
  - IDLE, aligned memory op: mem_stall=1 combinationally. Next edge: mem_req=1, mem_addr/mem_be/mem_we/mem_wdata registered, counter cleared, state goes to WAIT, mem_wb_writereg=0 (bubble).
  - WAIT: request signals are held stable. mem_stall = !mem_ready, combinational.
    - mem_ready=1: on the edge, mem_req=0 and state goes to IDLE.
      - Load: mem_wb_result = extracted lane, sign- or zero-extended per size/unsigned; mem_wb_writereg = ex_mem_writereg.
      - Store: mem_wb_writereg=0.
      - Upstream advances on the same edge, so the op is never reissued.
    - mem_ready=0 and counter==MAX_WAIT-1: on the edge, abort. mem_req=0, state goes to IDLE, mem_fault pulses, mem_wb_writereg=0. mem_stall is forced 0 in that cycle.
    - Otherwise the counter increments and mem_wb_writereg=0.
- Minimum memory-op latency is 2 cycles (issue, then ready). mem_ready outside WAIT is ignored.
- mem_fault is high for exactly one cycle per faulting op.

Decomposition:
- Shared package holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - FSM state typedef;
  - MAX_WAIT default.
- One sub-module, mem_lane_align, is combinational: it takes size, addr[1:0], unsigned, regb and rdata, and produces be, wdata, aligned load data and the misaligned flag.

Test Plan:
- Non-memory op, aluout=0x00000007, regdest=5, writereg=1 -> next cycle mem_wb_result=7, regdest=5, writereg=1, mem_stall never high.
- Word store at 0x10, regb=0xDEADBEEF, mem_ready after 3 cycles:
  - mem_addr=0x10, be=1111, wdata=0xDEADBEEF, we=1;
  - mem_stall high 4 cycles;
  - writereg stays 0.
- Byte load at 0x13, signed, rdata=0x80AABBCC -> mem_wb_result=0xFFFFFF80. Same load with unsigned=1 -> 0x00000080.
- Half load at 0x22, rdata=0x1234ABCD, unsigned=0 -> be=1100, mem_wb_result=0x00001234. Half at 0x21 -> mem_fault one cycle, no mem_req, no stall.
- mem_ready held 0 with MAX_WAIT=4 -> mem_req high 4 cycles then drops, mem_fault pulse, mem_stall falls, writereg=0.
- reset asserted low in WAIT -> mem_req=0 immediately; after release the FSM is in IDLE with no fault and no write-back.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the MIPS memory-access pipeline stage.
package mem_access_stage_pkg;

    localparam int unsigned DATA_W           = 32;
    localparam int unsigned BE_W             = 4;
    localparam int unsigned REG_W            = 5;
    localparam int unsigned CNT_W            = 8;
    localparam int unsigned MAX_WAIT_DEFAULT = 255;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane steering for stores and lane extraction/extension for loads.
module mem_lane_align
    import mem_access_stage_pkg::*;
(
    input  logic [1:0]        size,
    input  logic [1:0]        addr_lo,
    input  logic              is_unsigned,
    input  logic [DATA_W-1:0] regb,
    input  logic [DATA_W-1:0] rdata,
    output logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data,
    output logic              misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel   = rdata[{addr_lo, 3'b000} +: 8];
        half_sel   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        be         = '0;
        wdata      = regb;
        load_data  = rdata;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: begin
                be        = BE_W'(1) << addr_lo;
                wdata     = {4{regb[7:0]}};
                load_data = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{regb[15:0]}};
                load_data  = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
                misaligned = addr_lo[0];
            end
            // 2'b11 is treated as a word access
            default: begin
                be         = 4'b1111;
                misaligned = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEMORY pipeline stage: issues loads/stores over req/ready, stalls upstream while
// an access is outstanding, and registers the write-back result for WRITEBACK.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] ex_mem_aluout,
    input  logic [DATA_W-1:0] ex_mem_regb,
    input  logic              ex_mem_readmem,
    input  logic              ex_mem_writemem,
    input  logic [1:0]        ex_mem_size,
    input  logic              ex_mem_unsigned,
    input  logic [REG_W-1:0]  ex_mem_regdest,
    input  logic              ex_mem_writereg,
    output logic              mem_stall,
    output logic [DATA_W-1:0] mem_wb_result,
    output logic [REG_W-1:0]  mem_wb_regdest,
    output logic              mem_wb_writereg,
    output logic              mem_fault,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [BE_W-1:0]   mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e              state_q,    state_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic [DATA_W-1:0]   result_q,   result_d;
    logic [REG_W-1:0]    regdest_q,  regdest_d;
    logic                writereg_q, writereg_d;
    logic                fault_q,    fault_d;
    logic                req_q,      req_d;
    logic                we_q,       we_d;
    logic [DATA_W-1:0]   addr_q,     addr_d;
    logic [BE_W-1:0]     be_q,       be_d;
    logic [DATA_W-1:0]   wdata_q,    wdata_d;
    logic                stall_c;

    logic [BE_W-1:0]     lane_be;
    logic [DATA_W-1:0]   lane_wdata;
    logic [DATA_W-1:0]   lane_load;
    logic                lane_misaligned;
    logic                mem_op;
    logic                timeout;

    mem_lane_align u_lane_align (
        .size        (ex_mem_size),
        .addr_lo     (ex_mem_aluout[1:0]),
        .is_unsigned (ex_mem_unsigned),
        .regb        (ex_mem_regb),
        .rdata       (mem_rdata),
        .be          (lane_be),
        .wdata       (lane_wdata),
        .load_data   (lane_load),
        .misaligned  (lane_misaligned)
    );

    assign mem_op  = ex_mem_readmem | ex_mem_writemem;
    assign timeout = (cnt_q == CNT_W'(MAX_WAIT - 1));

    // Next-state, request and write-back computation
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        regdest_d  = ex_mem_regdest;
        writereg_d = 1'b0;
        fault_d    = 1'b0;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        stall_c    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                result_d = ex_mem_aluout;
                if (mem_op && lane_misaligned) begin
                    fault_d = 1'b1;
                end else if (mem_op) begin
                    stall_c = 1'b1;
                    req_d   = 1'b1;
                    we_d    = ex_mem_writemem;
                    addr_d  = {ex_mem_aluout[31:2], 2'b00};
                    be_d    = lane_be;
                    wdata_d = lane_wdata;
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end else begin
                    writereg_d = ex_mem_writereg;
                end
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = ST_IDLE;
                    if (ex_mem_readmem) begin
                        result_d   = lane_load;
                        writereg_d = ex_mem_writereg;
                    end
                end else if (timeout) begin
                    // Abort: upstream is released this cycle so the op is dropped
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    fault_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            result_q   <= '0;
            regdest_q  <= '0;
            writereg_q <= 1'b0;
            fault_q    <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            regdest_q  <= regdest_d;
            writereg_q <= writereg_d;
            fault_q    <= fault_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
        end
    end

    assign mem_stall       = stall_c;
    assign mem_wb_result   = result_q;
    assign mem_wb_regdest  = regdest_q;
    assign mem_wb_writereg = writereg_q;
    assign mem_fault       = fault_q;
    assign mem_req         = req_q;
    assign mem_we          = we_q;
    assign mem_addr        = addr_q;
    assign mem_be          = be_q;
    assign mem_wdata       = wdata_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed scoreboard bench for mem_access_stage; the bench also plays the RAM.
module tb_mem_access_stage;

    localparam int unsigned MAXW = 4;

    logic        clock;
    logic        reset;
    logic [31:0] ex_mem_aluout;
    logic [31:0] ex_mem_regb;
    logic        ex_mem_readmem;
    logic        ex_mem_writemem;
    logic [1:0]  ex_mem_size;
    logic        ex_mem_unsigned;
    logic [4:0]  ex_mem_regdest;
    logic        ex_mem_writereg;
    logic        mem_stall;
    logic [31:0] mem_wb_result;
    logic [4:0]  mem_wb_regdest;
    logic        mem_wb_writereg;
    logic        mem_fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    typedef struct {
        logic [31:0] result;
        logic        chk_result;
        logic [4:0]  regdest;
        logic        writereg;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mem_access_stage #(.MAX_WAIT(MAXW)) dut (
        .clock           (clock),
        .reset           (reset),
        .ex_mem_aluout   (ex_mem_aluout),
        .ex_mem_regb     (ex_mem_regb),
        .ex_mem_readmem  (ex_mem_readmem),
        .ex_mem_writemem (ex_mem_writemem),
        .ex_mem_size     (ex_mem_size),
        .ex_mem_unsigned (ex_mem_unsigned),
        .ex_mem_regdest  (ex_mem_regdest),
        .ex_mem_writereg (ex_mem_writereg),
        .mem_stall       (mem_stall),
        .mem_wb_result   (mem_wb_result),
        .mem_wb_regdest  (mem_wb_regdest),
        .mem_wb_writereg (mem_wb_writereg),
        .mem_fault       (mem_fault),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_be          (mem_be),
        .mem_wdata       (mem_wdata),
        .mem_ready       (mem_ready),
        .mem_rdata       (mem_rdata)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_nop();
        ex_mem_aluout   = 32'h0;
        ex_mem_regb     = 32'h0;
        ex_mem_readmem  = 1'b0;
        ex_mem_writemem = 1'b0;
        ex_mem_size     = 2'b10;
        ex_mem_unsigned = 1'b0;
        ex_mem_regdest  = 5'd0;
        ex_mem_writereg = 1'b0;
    endtask

    // Drive one op, act as the RAM with 'delay' not-ready cycles, then check write-back.
    // e_cycles: expected stall cycles, which also equals the cycles mem_req is high.
    task automatic run_op(input string tag, input logic [31:0] alu, input logic [31:0] regb,
                          input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [4:0] rdest, input logic wreg, input int delay,
                          input logic [31:0] rdata, input logic [3:0] e_be,
                          input logic [31:0] e_wdata, input logic [31:0] e_result,
                          input logic chk_res, input logic e_wreg, input logic e_fault,
                          input int e_cycles);
        exp_t e;
        int   req_cycles;
        int   stalls;
        logic stall_now;
        logic done;
        ex_mem_aluout   = alu;
        ex_mem_regb     = regb;
        ex_mem_readmem  = rd;
        ex_mem_writemem = wr;
        ex_mem_size     = sz;
        ex_mem_unsigned = uns;
        ex_mem_regdest  = rdest;
        ex_mem_writereg = wreg;
        sb.push_back('{result: e_result, chk_result: chk_res, regdest: rdest,
                       writereg: e_wreg, fault: e_fault});
        req_cycles = 0;
        stalls     = 0;
        done       = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (mem_req) begin
                req_cycles++;
                if (req_cycles == 1) begin
                    chk({tag, "/addr"}, mem_addr, {alu[31:2], 2'b00});
                    chk({tag, "/be"}, 32'(mem_be), 32'(e_be));
                    chk({tag, "/we"}, 32'(mem_we), 32'(wr));
                    if (wr) chk({tag, "/wdata"}, mem_wdata, e_wdata);
                end
                mem_ready = (req_cycles > delay);
            end else begin
                mem_ready = 1'b0;
            end
            mem_rdata = rdata;
            #1;
            stall_now = mem_stall;
            if (stall_now) stalls++;
            @(posedge clock);
            #2;
            if (!stall_now) begin
                done = 1'b1;
                break;
            end
        end
        mem_ready = 1'b0;
        chk({tag, "/completed"}, 32'(done), 32'd1);
        e = sb.pop_front();
        if (e.chk_result) chk({tag, "/result"}, mem_wb_result, e.result);
        chk({tag, "/regdest"}, 32'(mem_wb_regdest), 32'(e.regdest));
        chk({tag, "/writereg"}, 32'(mem_wb_writereg), 32'(e.writereg));
        chk({tag, "/fault"}, 32'(mem_fault), 32'(e.fault));
        chk({tag, "/stall_cycles"}, 32'(stalls), 32'(e_cycles));
        chk({tag, "/req_cycles"}, 32'(req_cycles), 32'(e_cycles));
        chk({tag, "/req_after"}, 32'(mem_req), 32'd0);
        drive_nop();
        @(posedge clock);
        #2;
        chk({tag, "/fault_one_cycle"}, 32'(mem_fault), 32'd0);
    endtask

    initial begin
        clock     = 1'b0;
        reset     = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        drive_nop();
        repeat (2) @(posedge clock);
        #2;
        chk("rst/req", 32'(mem_req), 32'd0);
        chk("rst/result", mem_wb_result, 32'h0);
        chk("rst/writereg", 32'(mem_wb_writereg), 32'd0);
        chk("rst/fault", 32'(mem_fault), 32'd0);
        chk("rst/be", 32'(mem_be), 32'd0);
        reset = 1'b1;
        @(posedge clock);
        #2;

        //     tag       alu          regb         rd   wr   sz     uns  rd#    wreg dly rdata         be       wdata        result       chk  ewr  eflt cyc
        run_op("alu",    32'h7,       32'h0,       0,   0,   2'b10, 0,   5'd5,  1,   0,  32'h0,        4'b0000, 32'h0,       32'h7,       1,   1,   0,   0);
        run_op("sw",     32'h10,      32'hDEADBEEF,0,   1,   2'b10, 0,   5'd2,  1,   3,  32'h0,        4'b1111, 32'hDEADBEEF,32'h0,       0,   0,   0,   4);
        run_op("lb_s",   32'h13,      32'h0,       1,   0,   2'b00, 0,   5'd9,  1,   1,  32'h80AABBCC, 4'b1000, 32'h0,       32'hFFFFFF80,1,   1,   0,   2);
        run_op("lb_u",   32'h13,      32'h0,       1,   0,   2'b00, 1,   5'd9,  1,   1,  32'h80AABBCC, 4'b1000, 32'h0,       32'h00000080,1,   1,   0,   2);
        run_op("lh_hi",  32'h22,      32'h0,       1,   0,   2'b01, 0,   5'd4,  1,   0,  32'h1234ABCD, 4'b1100, 32'h0,       32'h00001234,1,   1,   0,   1);
        run_op("lh_mis", 32'h21,      32'h0,       1,   0,   2'b01, 0,   5'd4,  1,   0,  32'h1234ABCD, 4'b0000, 32'h0,       32'h0,       0,   0,   1,   0);
        run_op("lh_lo",  32'h30,      32'h0,       1,   0,   2'b01, 0,   5'd7,  1,   2,  32'h5555F00D, 4'b0011, 32'h0,       32'hFFFFF00D,1,   1,   0,   3);
        run_op("sh",     32'h16,      32'h0000CAFE,0,   1,   2'b01, 0,   5'd0,  0,   2,  32'h0,        4'b1100, 32'hCAFECAFE,32'h0,       0,   0,   0,   3);
        run_op("sb",     32'h11,      32'h1234565A,0,   1,   2'b00, 0,   5'd0,  0,   0,  32'h0,        4'b0010, 32'h5A5A5A5A,32'h0,       0,   0,   0,   1);
        run_op("sw_mis", 32'h2A,      32'h11111111,0,   1,   2'b11, 0,   5'd0,  0,   0,  32'h0,        4'b0000, 32'h0,       32'h0,       0,   0,   1,   0);
        run_op("lw_to",  32'h24,      32'h0,       1,   0,   2'b10, 0,   5'd8,  1,   50, 32'hFFFFFFFF, 4'b1111, 32'h0,       32'h0,       0,   0,   1,   4);
        run_op("lw_11",  32'h44,      32'h0,       1,   0,   2'b11, 1,   5'd6,  1,   1,  32'hA5A5_0F0F,4'b1111, 32'h0,       32'hA5A50F0F,1,   1,   0,   2);

        // Reset in the middle of an outstanding access
        ex_mem_aluout   = 32'h40;
        ex_mem_readmem  = 1'b1;
        ex_mem_size     = 2'b10;
        ex_mem_regdest  = 5'd3;
        ex_mem_writereg = 1'b1;
        @(posedge clock);
        #2;
        chk("midrst/req_issued", 32'(mem_req), 32'd1);
        @(posedge clock);
        #2;
        drive_nop();
        mem_ready = 1'b1;
        reset     = 1'b0;
        #1;
        chk("midrst/req_dropped", 32'(mem_req), 32'd0);
        chk("midrst/writereg", 32'(mem_wb_writereg), 32'd0);
        chk("midrst/fault", 32'(mem_fault), 32'd0);
        @(posedge clock);
        #2;
        mem_ready = 1'b0;
        reset     = 1'b1;
        @(posedge clock);
        #2;
        chk("postrst/fault", 32'(mem_fault), 32'd0);
        chk("postrst/writereg", 32'(mem_wb_writereg), 32'd0);
        run_op("postrst_alu", 32'h55, 32'h0, 0, 0, 2'b10, 0, 5'd3, 1, 0, 32'h0, 4'b0000,
               32'h0, 32'h55, 1, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
